// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit: sequential instruction fetch with a credit-limited
// in-order prefetch queue. Redirects flush the queue and drop responses
// that are still in flight when the redirect happens.
//
// Handshakes: memory request is accepted in any cycle with mem_req && mem_gnt;
// responses (mem_rvalid) are always accepted and return in request order;
// the core consumes the queue head in any cycle with instr_valid && instr_ready.
module rv32_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misaligned
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            misaligned_q, misaligned_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [XLEN-1:0] q_instr_q [DEPTH];

    logic            grant;
    logic            pop;
    logic            push;
    logic            wr_en;
    logic [CW:0]     inflight;

    // Queue slots already promised: entries held plus responses still owed.
    assign inflight    = {1'b0, count_q} + {1'b0, outstanding_q};
    assign mem_req     = !rst && !redirect && !misaligned_q && (inflight < (CW+1)'(DEPTH));
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = q_instr_q[rd_ptr_q];
    assign instr_pc    = q_pc_q[rd_ptr_q];
    assign misaligned  = misaligned_q;

    // Next-state: fetch/response PCs, occupancy counters and redirect flush.
    always_comb begin
        grant         = mem_req && mem_gnt;
        pop           = instr_valid && instr_ready;
        push          = mem_rvalid && (discard_q == '0);
        wr_en         = push && !redirect;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        misaligned_d  = misaligned_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);

        case ({grant, mem_rvalid})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (mem_rvalid && !push) discard_d = discard_q - 1'b1;

        if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
            wr_ptr_d  = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        // Redirect wins: everything queued or still owed is stale.
        if (redirect) begin
            fetch_pc_d   = redirect_pc;
            resp_pc_d    = redirect_pc;
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            discard_d    = outstanding_d;
            misaligned_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            misaligned_q  <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misaligned_q  <= misaligned_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else if (wr_en) begin
            q_pc_q[wr_ptr_q]    <= resp_pc_q;
            q_instr_q[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule
